gyro_spi_reader: RTL

Periodic SPI master that wakes the IMU and reads its three 16-bit gyro rate registers. It then presents them as `gx`/`gy`/`gz` with a one-cycle valid strobe. It is the producer feeding `process_gyro`: it replaces the free-running sample of raw inputs with a fixed-rate, coherent burst read.

---
 rtl/gyro_spi_reader.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/gyro_spi_reader.sv
// Periodic mode-3 SPI master: wakes the IMU once, then burst-reads the
// six gyro rate bytes every SAMPLE_PERIOD cycles and publishes gx/gy/gz.
module gyro_spi_reader #(
  parameter int          CLK_DIV       = 50,
  parameter int          SAMPLE_PERIOD = 100000,
  parameter logic [7:0]  WAKE_REG      = 8'h6B,
  parameter logic [7:0]  WAKE_VAL      = 8'h00,
  parameter logic [7:0]  GYRO_REG      = 8'h43
) (
  input  logic        clk_100mhz,
  input  logic        rst_in,
  input  logic        miso,
  output logic        sclk,
  output logic        mosi,
  output logic        cs_n,
  output logic [15:0] gx,
  output logic [15:0] gy,
  output logic [15:0] gz,
  output logic        data_valid,
  output logic        overrun
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(SAMPLE_PERIOD - 1);

  typedef enum logic [2:0] {
    S_WAKE, S_GAP, S_IDLE, S_READ, S_PUBLISH
  } state_t;

  typedef enum logic [2:0] {
    P_OFF, P_SETUP, P_LOW, P_HIGH, P_HOLD
  } phase_t;

  state_t        state;
  state_t        state_nx;
  phase_t        phase;
  logic [DW-1:0] div_cnt;
  logic [5:0]    bit_cnt;
  logic [5:0]    bit_last;
  logic [55:0]   tx_sr;
  logic [47:0]   rx_sr;
  logic [TW-1:0] timer;
  logic          timer_en;
  logic          div_done;
  logic          xfer_start;
  logic          xfer_done;
  logic          tick;

  assign div_done   = (div_cnt == DIV_LAST);
  assign xfer_done  = (phase == P_HOLD) && div_done;
  assign tick       = timer_en && (timer == '0);
  assign xfer_start = ((state == S_WAKE) && (phase == P_OFF)) ||
                      ((state == S_IDLE) && tick);

  always_ff @(posedge clk_100mhz) begin
    if (rst_in) state <= S_WAKE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_WAKE:    if (xfer_done) state_nx = S_GAP;
      S_GAP:     if (div_done)  state_nx = S_IDLE;
      S_IDLE:    if (tick)      state_nx = S_READ;
      S_READ:    if (xfer_done) state_nx = S_PUBLISH;
      S_PUBLISH: state_nx = S_IDLE;
      default:   state_nx = S_WAKE;
    endcase
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst_in) begin
      phase      <= P_OFF;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      bit_last   <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      timer      <= '0;
      timer_en   <= 1'b0;
      sclk       <= 1'b1;
      mosi       <= 1'b1;
      cs_n       <= 1'b1;
      gx         <= '0;
      gy         <= '0;
      gz         <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      data_valid <= 1'b0;

      // Timer restarts from 0 as GAP ends so the first read follows at once
      if ((state == S_GAP) && div_done) begin
        timer    <= '0;
        timer_en <= 1'b1;
      end else if (timer_en) begin
        timer <= (timer == TMR_LAST) ? '0 : timer + 1'b1;
      end

      if (tick && (state != S_IDLE)) overrun <= 1'b1;

      if ((phase != P_OFF) || (state == S_GAP))
        div_cnt <= div_done ? '0 : div_cnt + 1'b1;
      else
        div_cnt <= '0;

      if (xfer_start) begin
        phase   <= P_SETUP;
        cs_n    <= 1'b0;
        bit_cnt <= '0;
        if (state == S_WAKE) begin
          tx_sr    <= {1'b0, WAKE_REG[6:0], WAKE_VAL, 40'h0};
          bit_last <= 6'd15;
        end else begin
          tx_sr    <= {1'b1, GYRO_REG[6:0], 48'h0};
          bit_last <= 6'd55;
        end
      end else if (div_done) begin
        unique case (phase)
          P_SETUP: begin
            phase <= P_LOW;
            sclk  <= 1'b0;
            mosi  <= tx_sr[55];
            tx_sr <= {tx_sr[54:0], 1'b0};
          end
          P_LOW: begin
            phase <= P_HIGH;
            sclk  <= 1'b1;
            rx_sr <= {rx_sr[46:0], miso};
          end
          P_HIGH: begin
            if (bit_cnt == bit_last) begin
              phase <= P_HOLD;
            end else begin
              phase   <= P_LOW;
              sclk    <= 1'b0;
              mosi    <= tx_sr[55];
              tx_sr   <= {tx_sr[54:0], 1'b0};
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
          P_HOLD: begin
            phase <= P_OFF;
            cs_n  <= 1'b1;
            mosi  <= 1'b1;
          end
          default: ;
        endcase
      end

      // Command byte has shifted out of rx_sr; it holds bytes 1..6 only
      if (state == S_PUBLISH) begin
        gx         <= rx_sr[47:32];
        gy         <= rx_sr[31:16];
        gz         <= rx_sr[15:0];
        data_valid <= 1'b1;
      end
    end
  end

endmodule
